// File: rtl/capture_integrator.sv
// Sync-derived active window with a saturating per-channel integrator per pixel and
// optional frame-to-frame persistence through an external simple dual-port frame RAM.
module capture_integrator #(
  parameter int CHANNELS = 3,
  parameter int ACC_W    = 5,
  parameter int MEM_W    = 4,
  parameter int DECIM    = 2,
  parameter int H_SKIP   = 40,
  parameter int H_ACTIVE = 800,
  parameter int V_SKIP   = 0,
  parameter int V_ACTIVE = 600,
  parameter int ADDR_W   = 18
) (
  input  logic                        clock,
  input  logic                        reset_n,
  input  logic                        hsync_n,
  input  logic                        vsync_n,
  input  logic [CHANNELS-1:0]         comp,
  input  logic [1:0]                  mode,
  output logic [ADDR_W-1:0]           mem_rd_addr,
  input  logic [CHANNELS*MEM_W-1:0]   mem_rd_data,
  output logic [ADDR_W-1:0]           mem_wr_addr,
  output logic [CHANNELS*MEM_W-1:0]   mem_wr_data,
  output logic                        mem_wr_en,
  output logic [CHANNELS*ACC_W-1:0]   pix_out,
  output logic                        pix_valid,
  output logic                        frame_start
);
  localparam logic [11:0] DMASK = 12'(DECIM - 1);
  localparam logic [11:0] HS    = 12'(H_SKIP);
  localparam logic [11:0] HA    = 12'(H_ACTIVE);
  localparam logic [11:0] VS    = 12'(V_SKIP);
  localparam logic [11:0] VA    = 12'(V_ACTIVE);

  logic [CHANNELS-1:0] comp_sync;
  logic hs_sync, hs_prev, vs_sync, vs_prev;
  logic [11:0] col, row, col_nxt, col_off, nxt_off;
  logic [ADDR_W-1:0] samp, samp_nxt;
  logic [1:0] mode_lat;
  logic armed;
  logic hs_rise, vs_rise, vs_fall, col_act, row_act, active, first, last, next_last;
  logic [CHANNELS-1:0][MEM_W-1:0] ram_in, rd_hold, wr_nxt;
  logic [CHANNELS-1:0][ACC_W-1:0] acc, acc_nxt;

  function automatic logic [ACC_W-1:0] step(input logic [ACC_W-1:0] v, input logic up);
    if (up) step = (&v) ? v : v + ACC_W'(1);
    else    step = (v == '0) ? v : v - ACC_W'(1);
  endfunction

  function automatic logic [ACC_W-1:0] load(input logic [MEM_W-1:0] v);
    load = ACC_W'(v) << (ACC_W - MEM_W);
  endfunction

  assign ram_in  = mem_rd_data;
  assign hs_rise = hs_sync & ~hs_prev;
  assign vs_rise = vs_sync & ~vs_prev;
  assign vs_fall = ~vs_sync & vs_prev;
  // Offset compares wrap below the skip, so one unsigned test covers both window bounds.
  assign col_off = col - HS;
  assign col_act = col_off < HA;
  assign row_act = (row - VS) < VA;
  assign active  = armed & vs_sync & col_act & row_act;
  assign first   = (col_off & DMASK) == 12'd0;
  assign last    = (col_off & DMASK) == DMASK;
  assign nxt_off = col_nxt - HS;
  assign next_last = armed & vs_sync & row_act & (nxt_off < HA) & ((nxt_off & DMASK) == DMASK);

  always_comb begin
    if (hs_rise)             col_nxt = 12'd0;
    else if (col == 12'hFFF) col_nxt = col;
    else                     col_nxt = col + 12'd1;
  end

  always_comb begin
    if (!vs_sync)             samp_nxt = '0;
    else if (active && last)  samp_nxt = samp + ADDR_W'(1);
    else                      samp_nxt = samp;
  end

  // Stored samples only arrive during `first`; later phases of the sample use the held copy.
  always_comb begin
    acc_nxt = acc;
    wr_nxt  = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (active) begin
        case (mode_lat)
          2'd0:    acc_nxt[i] = step(acc[i], comp_sync[i]);
          2'd1:    acc_nxt[i] = step(first ? load(ram_in[i]) : acc[i], comp_sync[i]);
          2'd2:    acc_nxt[i] = load(first ? ram_in[i] : rd_hold[i]);
          default: acc_nxt[i] = '0;
        endcase
      end else if (mode_lat != 2'd0) begin
        acc_nxt[i] = '0;
      end else begin
        acc_nxt[i] = acc[i];
      end
      wr_nxt[i] = acc_nxt[i][ACC_W-1 -: MEM_W];
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      comp_sync <= '0;
      hs_sync   <= 1'b0;
      hs_prev   <= 1'b0;
      vs_sync   <= 1'b0;
      vs_prev   <= 1'b0;
    end else begin
      comp_sync <= comp;
      hs_sync   <= hsync_n;
      hs_prev   <= hs_sync;
      vs_sync   <= vsync_n;
      vs_prev   <= vs_sync;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      col      <= '0;
      row      <= '0;
      samp     <= '0;
      mode_lat <= 2'd0;
      armed    <= 1'b0;
      rd_hold  <= '0;
      acc      <= '0;
    end else begin
      col  <= col_nxt;
      samp <= samp_nxt;
      acc  <= acc_nxt;
      if (vs_rise)                     row <= 12'd0;
      else if (hs_rise && row != 12'hFFF) row <= row + 12'd1;
      if (vs_fall) begin
        mode_lat <= mode;
        armed    <= 1'b1;
      end
      if (active && first) rd_hold <= ram_in;
    end
  end

  // The read address leads by one sample so RAM data lines up with the `first` cycle.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mem_rd_addr <= '0;
      mem_wr_addr <= '0;
      mem_wr_data <= '0;
      mem_wr_en   <= 1'b0;
      pix_out     <= '0;
      pix_valid   <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      mem_rd_addr <= samp_nxt + ADDR_W'(next_last);
      mem_wr_addr <= samp;
      mem_wr_data <= wr_nxt;
      mem_wr_en   <= active & last & mode_lat[0];
      pix_out     <= active ? acc_nxt : '0;
      pix_valid   <= active;
      frame_start <= vs_fall;
    end
  end
endmodule

// File: tb/tb_capture_integrator.sv
// Randomised scoreboard bench for capture_integrator: a per-pixel reference model pushes
// expected pixels and RAM writes; a monitor pops and compares whenever the DUT presents them.
module tb_capture_integrator;
  localparam int CH = 3, AW = 5, MW = 4, DEC = 2, HSK = 40, HACT = 64, VSK = 1, VACT = 4, ADW = 18;
  localparam int LINE = 120, HS_LOW = 4, LINES = 8, NF = 11, RST_F = 8;
  localparam int SPL = HACT / DEC;
  localparam int NSAMP = SPL * VACT;
  localparam int AMAX = (1 << AW) - 1;

  logic clock = 1'b0;
  logic reset_n, hsync_n, vsync_n;
  logic [CH-1:0] comp;
  logic [1:0] mode;
  logic [ADW-1:0] mem_rd_addr, mem_wr_addr;
  logic [CH*MW-1:0] mem_rd_data, mem_wr_data;
  logic mem_wr_en, pix_valid, frame_start;
  logic [CH*AW-1:0] pix_out;

  capture_integrator #(
    .CHANNELS(CH), .ACC_W(AW), .MEM_W(MW), .DECIM(DEC), .H_SKIP(HSK), .H_ACTIVE(HACT),
    .V_SKIP(VSK), .V_ACTIVE(VACT), .ADDR_W(ADW)
  ) dut (
    .clock(clock), .reset_n(reset_n), .hsync_n(hsync_n), .vsync_n(vsync_n), .comp(comp),
    .mode(mode), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
    .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data), .mem_wr_en(mem_wr_en),
    .pix_out(pix_out), .pix_valid(pix_valid), .frame_start(frame_start)
  );

  always #5 clock = ~clock;

  int n_checks = 0, n_errors = 0;
  int cyc = 0, hs_rise_cyc = 0, vs_fall_cyc = 0, fs_count = 0;
  logic [CH*AW-1:0] exp_q[$];
  logic [ADW+CH*MW-1:0] wr_q[$];
  logic [CH*MW-1:0] model_ram [0:NSAMP-1];
  logic [CH*MW-1:0] ram [0:(1<<ADW)-1];
  bit do_preload = 1'b1;
  int macc[CH];
  int mm = 0;
  bit captured = 1'b0;
  int mode_plan[NF] = '{0, 0, 0, 1, 1, 2, 3, 2, 0, 1, 2};
  int pat_plan[NF]  = '{1, 2, 3, 1, 0, 0, 0, 0, 0, 0, 0};

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic int stepf(int v, bit up);
    if (up) return (v == AMAX) ? v : v + 1;
    return (v == 0) ? 0 : v - 1;
  endfunction

  // Reference: one active pixel of row rr, column c, in frame mode mm.
  task automatic model_pixel(int rr, int c, logic [CH-1:0] cb);
    int a;
    bit fst, lst;
    logic [CH*AW-1:0] pv;
    logic [CH*MW-1:0] wd;
    a   = rr * SPL + c / DEC;
    fst = (c % DEC) == 0;
    lst = (c % DEC) == DEC - 1;
    for (int ch = 0; ch < CH; ch++) begin
      int nib;
      nib = int'((model_ram[a] >> (MW * ch)) & 12'hF);
      case (mm)
        0: macc[ch] = stepf(macc[ch], cb[ch]);
        1: begin
          if (fst) macc[ch] = nib << (AW - MW);
          macc[ch] = stepf(macc[ch], cb[ch]);
        end
        2: macc[ch] = nib << (AW - MW);
        default: macc[ch] = 0;
      endcase
      pv[ch*AW +: AW] = AW'(macc[ch]);
      wd[ch*MW +: MW] = MW'(macc[ch] >> (AW - MW));
    end
    exp_q.push_back(pv);
    if (lst && (mm == 1 || mm == 3)) begin
      wr_q.push_back({ADW'(a), wd});
      model_ram[a] = wd;
    end
  endtask

  always @(posedge clock) cyc <= cyc + 1;

  always @(posedge clock) begin
    if (do_preload) begin
      for (int a = 0; a < NSAMP; a++) ram[a] <= model_ram[a];
    end else if (mem_wr_en) begin
      ram[mem_wr_addr] <= mem_wr_data;
    end
    mem_rd_data <= ram[mem_rd_addr];
  end

  // Monitor: pops expectations whenever the DUT presents a pixel, a write or a frame pulse.
  bit prev_v = 1'b0;
  int run = 0;
  always @(posedge clock) begin
    #1;
    if (!reset_n) begin
      prev_v = 1'b0;
      run = 0;
    end else begin
      if (pix_valid) begin
        run++;
        if (!prev_v) chk("valid_onset", 64'(cyc - hs_rise_cyc), 64'(HSK + 3));
        if (exp_q.size() == 0) chk("pix_unexpected", 64'(pix_out), 64'hDEAD);
        else chk("pix_out", 64'(pix_out), 64'(exp_q.pop_front()));
      end else begin
        chk("pix_idle_zero", 64'(pix_out), 64'd0);
        if (prev_v) chk("valid_run_len", 64'(run), 64'(HACT));
        run = 0;
      end
      prev_v = pix_valid;
      if (mem_wr_en) begin
        if (wr_q.size() == 0) chk("wr_unexpected", 64'({mem_wr_addr, mem_wr_data}), 64'hDEAD);
        else chk("wr_addr_data", 64'({mem_wr_addr, mem_wr_data}), 64'(wr_q.pop_front()));
      end
      if (frame_start) begin
        fs_count++;
        chk("frame_start_time", 64'(cyc - vs_fall_cyc), 64'd2);
      end
    end
  end

  initial begin
    reset_n = 1'b0; hsync_n = 1'b1; vsync_n = 1'b1; comp = '0; mode = 2'd0;
    for (int a = 0; a < NSAMP; a++) model_ram[a] = 12'($urandom_range(0, 4095));
    model_ram[0] = 12'hAAA;
    for (int ch = 0; ch < CH; ch++) macc[ch] = 0;
    repeat (3) @(negedge clock);
    chk("reset_pix_valid", 64'(pix_valid), 64'd0);
    chk("reset_outputs", 64'({pix_out, mem_wr_en, frame_start, mem_rd_addr}), 64'd0);
    do_preload = 1'b0;
    reset_n = 1'b1;
    repeat (5) @(negedge clock);
    mode = 2'(mode_plan[0]);
    for (int f = 0; f < NF; f++) begin
      for (int l = 0; l < LINES; l++) begin
        for (int k = 0; k < LINE; k++) begin
          int c, rr;
          @(negedge clock);
          hsync_n = (k >= HS_LOW);
          vsync_n = (l >= 2);
          if (k == HS_LOW) hs_rise_cyc = cyc;
          if (l == 0 && k == 0) begin
            vs_fall_cyc = cyc;
            mm = int'(mode);
            captured = 1'b1;
          end
          if (k == 0 && mm != 0) for (int ch = 0; ch < CH; ch++) macc[ch] = 0;
          if (l == 4 && k == 0 && f + 1 < NF) mode = 2'(mode_plan[f + 1]);
          if (f == RST_F && l == 3 && k == 70) begin
            reset_n = 1'b0;
            #1;
            chk("async_reset_valid", 64'(pix_valid), 64'd0);
            chk("async_reset_outs", 64'({pix_out, mem_wr_en, mem_wr_addr, mem_rd_addr}), 64'd0);
            exp_q.delete();
            wr_q.delete();
            captured = 1'b0;
            for (int ch = 0; ch < CH; ch++) macc[ch] = 0;
          end
          if (f == RST_F && l == 3 && k == 71) reset_n = 1'b1;
          c  = k - (HS_LOW + 1 + HSK);
          rr = (l - 1) - VSK;
          if (c >= 0 && c < HACT && l >= 2 && rr >= 0 && rr < VACT) begin
            case (pat_plan[f])
              1: comp = 3'b111;
              2: comp = 3'b000;
              3: comp = (c % 2 == 0) ? 3'b111 : 3'b000;
              default: comp = 3'($urandom_range(0, 7));
            endcase
            if (captured) model_pixel(rr, c, comp);
          end else begin
            comp = 3'($urandom_range(0, 7));
          end
        end
      end
    end
    repeat (20) @(negedge clock);
    chk("pix_queue_drained", 64'(exp_q.size()), 64'd0);
    chk("wr_queue_drained", 64'(wr_q.size()), 64'd0);
    chk("frame_start_count", 64'(fs_count), 64'(NF));
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
